// File: rtl/dq_pkg.sv
// dq_pkg: micro-op types, LEGv8 opcode constants and the per-lane decode function
// Shared by decode_queue_ooo, its interface and its lane-compaction helper.
package dq_pkg;

    typedef enum logic [2:0] {
        CMD_ALU    = 3'd0,
        CMD_STORE  = 3'd1,
        CMD_LOAD   = 3'd2,
        CMD_BCOND  = 3'd3,
        CMD_MULDIV = 3'd4,
        CMD_CBZ    = 3'd5,
        CMD_BR     = 3'd6,
        CMD_BL     = 3'd7
    } cmd_t;

    typedef struct packed {
        cmd_t       cmd;
        logic [2:0] alu_op;
        logic       alu_src;
        logic       reg_write;
        logic       mem_write;
        logic       mem_read;
        logic       mem_to_reg;
        logic       save_cond;
        logic       uncond_br;
        logic [1:0] which_math;
        logic       left_shift;
        logic       illegal;
        logic [4:0] rd;
        logic [4:0] rn;
        logic [4:0] rm;
    } uop_t;

    localparam int UOP_W = $bits(uop_t);

    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_AND   = 3'd2;
    localparam logic [2:0] ALU_ORR   = 3'd3;
    localparam logic [2:0] ALU_EOR   = 3'd4;
    localparam logic [2:0] ALU_SHIFT = 3'd5;
    localparam logic [2:0] ALU_PASS  = 3'd6;

    localparam logic [10:0] OP_ADD   = 11'b10001011000;
    localparam logic [10:0] OP_ADDS  = 11'b10101011000;
    localparam logic [10:0] OP_SUB   = 11'b11001011000;
    localparam logic [10:0] OP_SUBS  = 11'b11101011000;
    localparam logic [10:0] OP_AND   = 11'b10001010000;
    localparam logic [10:0] OP_ORR   = 11'b10101010000;
    localparam logic [10:0] OP_EOR   = 11'b11001010000;
    localparam logic [10:0] OP_LSL   = 11'b11010011011;
    localparam logic [10:0] OP_LSR   = 11'b11010011010;
    localparam logic [10:0] OP_MUL   = 11'b10011011000;
    localparam logic [10:0] OP_SDIV  = 11'b10011010110;
    localparam logic [10:0] OP_LDUR  = 11'b11111000010;
    localparam logic [10:0] OP_STUR  = 11'b11111000000;
    localparam logic [10:0] OP_BR    = 11'b11010110000;
    localparam logic [9:0]  OP_ADDI  = 10'b1001000100;
    localparam logic [7:0]  OP_CBZ   = 8'b10110100;
    localparam logic [7:0]  OP_BCOND = 8'b01010100;
    localparam logic [5:0]  OP_B     = 6'b000101;
    localparam logic [5:0]  OP_BL    = 6'b100101;

    // Full 11-bit opcodes first; the shorter I/CB/B formats only when none of them match.
    function automatic uop_t decode_f(input logic [31:0] i);
        uop_t u;
        u = '0;
        u.rd = i[4:0];
        u.rn = i[9:5];
        u.rm = i[20:16];
        case (i[31:21])
            OP_ADD:  begin u.alu_op = ALU_ADD; u.reg_write = 1'b1; end
            OP_ADDS: begin u.alu_op = ALU_ADD; u.reg_write = 1'b1; u.save_cond = 1'b1; end
            OP_SUB:  begin u.alu_op = ALU_SUB; u.reg_write = 1'b1; end
            OP_SUBS: begin u.alu_op = ALU_SUB; u.reg_write = 1'b1; u.save_cond = 1'b1; end
            OP_AND:  begin u.alu_op = ALU_AND; u.reg_write = 1'b1; end
            OP_ORR:  begin u.alu_op = ALU_ORR; u.reg_write = 1'b1; end
            OP_EOR:  begin u.alu_op = ALU_EOR; u.reg_write = 1'b1; end
            OP_LSL:  begin u.alu_op = ALU_SHIFT; u.alu_src = 1'b1; u.left_shift = 1'b1; u.reg_write = 1'b1; end
            OP_LSR:  begin u.alu_op = ALU_SHIFT; u.alu_src = 1'b1; u.reg_write = 1'b1; end
            OP_MUL:  begin u.cmd = CMD_MULDIV; u.which_math = 2'd1; u.reg_write = 1'b1; end
            OP_SDIV: begin u.cmd = CMD_MULDIV; u.which_math = 2'd2; u.reg_write = 1'b1; end
            OP_LDUR: begin
                u.cmd = CMD_LOAD;
                u.alu_src = 1'b1;
                u.mem_read = 1'b1;
                u.mem_to_reg = 1'b1;
                u.reg_write = 1'b1;
            end
            OP_STUR: begin u.cmd = CMD_STORE; u.alu_src = 1'b1; u.mem_write = 1'b1; end
            OP_BR:   begin u.cmd = CMD_BR; u.uncond_br = 1'b1; end
            default: begin
                if (i[31:22] == OP_ADDI) begin
                    u.alu_src = 1'b1;
                    u.reg_write = 1'b1;
                end else if (i[31:24] == OP_CBZ) begin
                    u.cmd = CMD_CBZ;
                    u.alu_op = ALU_PASS;
                end else if (i[31:24] == OP_BCOND) begin
                    u.cmd = CMD_BCOND;
                end else if (i[31:26] == OP_B) begin
                    u.uncond_br = 1'b1;
                end else if (i[31:26] == OP_BL) begin
                    u.cmd = CMD_BL;
                    u.uncond_br = 1'b1;
                    u.reg_write = 1'b1;
                    u.rd = 5'd30;
                end else begin
                    u.illegal = 1'b1;
                end
            end
        endcase
        return u;
    endfunction

endpackage

// File: rtl/decode_queue_ooo_if.sv
// decode_queue_ooo_if: fetch-side enqueue group and dispatch-side micro-op handshake
// slave  = the queue (takes fetch group, flush, out_ready; drives in_ready, out_*, occupancy)
// master = the environment driving fetch and consuming micro-ops
interface decode_queue_ooo_if
    import dq_pkg::*;
#(
    parameter int FETCH_W = 2,
    parameter int DEPTH   = 8,
    parameter int PC_W    = 64
) ();
    logic                       flush;
    logic                       in_valid;
    logic [FETCH_W-1:0]         in_lane_valid;
    logic [32*FETCH_W-1:0]      in_instr;
    logic [PC_W*FETCH_W-1:0]    in_pc;
    logic                       in_ready;
    logic                       out_valid;
    logic                       out_ready;
    uop_t                       out_uop;
    logic [PC_W-1:0]            out_pc;
    logic [$clog2(DEPTH+1)-1:0] occupancy;

    modport slave (
        input  flush, in_valid, in_lane_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_uop, out_pc, occupancy
    );

    modport master (
        output flush, in_valid, in_lane_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_uop, out_pc, occupancy
    );
endinterface

// File: rtl/dq_lane_compact.sv
// dq_lane_compact: per-lane write offset (count of valid lanes below it) and total push count
// lane_valid in: per-lane valid; off out: slot offset from tail per lane; cnt out: popcount
module dq_lane_compact #(
    parameter int FETCH_W = 2
) (
    input  logic [FETCH_W-1:0]           lane_valid,
    output logic [$clog2(FETCH_W+1)-1:0] off [FETCH_W],
    output logic [$clog2(FETCH_W+1)-1:0] cnt
);
    localparam int CW = $clog2(FETCH_W + 1);

    always_comb begin
        cnt = '0;
        for (int i = 0; i < FETCH_W; i++) begin
            off[i] = cnt;
            cnt = cnt + CW'(lane_valid[i]);
        end
    end
endmodule

// File: rtl/decode_queue_ooo.sv
// decode_queue_ooo: decodes up to FETCH_W LEGv8 instructions per cycle into an in-order micro-op queue
// clk, reset (sync, active-high); dq.slave carries flush, the fetch group (in_*),
// the dispatch handshake (out_*) and occupancy.
// Optional macro DQ_BYPASS_EN: same-cycle bypass of the lowest pushed lane into an empty queue.
module decode_queue_ooo
    import dq_pkg::*;
#(
    parameter int FETCH_W = 2,
    parameter int DEPTH   = 8,
    parameter int PC_W    = 64
) (
    input logic               clk,
    input logic               reset,
    decode_queue_ooo_if.slave dq
);
    localparam int PW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH + 1);
    localparam int CW = $clog2(FETCH_W + 1);

    uop_t            mem [DEPTH];
    logic [PC_W-1:0] pcs [DEPTH];
    logic [PW-1:0]   head, tail;
    logic [OW-1:0]   occ;
    uop_t            dec [FETCH_W];
    logic [CW-1:0]   off [FETCH_W];
    logic [PW-1:0]   slot [FETCH_W];
    logic [FETCH_W-1:0] wr;
    logic [CW-1:0]   cnt, n_push;
    logic            push, pop, byp;

    dq_lane_compact #(.FETCH_W(FETCH_W)) u_compact (
        .lane_valid(dq.in_lane_valid),
        .off       (off),
        .cnt       (cnt)
    );

    // in_ready looks only at registered occupancy so it never depends on out_ready or flush.
    assign dq.in_ready  = occ <= OW'(DEPTH - FETCH_W);
    assign dq.occupancy = occ;
    assign push = dq.in_valid && dq.in_ready && !dq.flush;
    assign pop  = occ != '0 && dq.out_ready;

`ifdef DQ_BYPASS_EN
    uop_t            byp_uop;
    logic [PC_W-1:0] byp_pc;

    // Only the first valid lane has offset 0 among the valid lanes.
    always_comb begin
        byp_uop = '0;
        byp_pc = '0;
        for (int i = 0; i < FETCH_W; i++) begin
            if (dq.in_lane_valid[i] && off[i] == '0) begin
                byp_uop = dec[i];
                byp_pc = dq.in_pc[PC_W*i +: PC_W];
            end
        end
    end

    assign byp          = push && occ == '0 && dq.out_ready && cnt != '0;
    assign dq.out_valid = occ != '0 || byp;
    assign dq.out_uop   = occ != '0 ? mem[head] : byp ? byp_uop : '0;
    assign dq.out_pc    = occ != '0 ? pcs[head] : byp ? byp_pc : '0;
`else
    assign byp          = 1'b0;
    assign dq.out_valid = occ != '0;
    assign dq.out_uop   = occ != '0 ? mem[head] : '0;
    assign dq.out_pc    = occ != '0 ? pcs[head] : '0;
`endif

    // A bypassed lane is not stored, so every later lane slides down one slot.
    always_comb begin
        n_push = push ? cnt - CW'(byp) : '0;
        for (int i = 0; i < FETCH_W; i++) begin
            dec[i] = decode_f(dq.in_instr[32*i +: 32]);
            slot[i] = tail + PW'(off[i]) - PW'(byp);
            wr[i] = push && dq.in_lane_valid[i] && !(byp && off[i] == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || dq.flush) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else begin
            if (push) tail <= tail + PW'(n_push);
            if (pop) head <= head + PW'(1);
            occ <= occ + OW'(n_push) - OW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < FETCH_W; i++) begin
            if (wr[i]) begin
                mem[slot[i]] <= dec[i];
                pcs[slot[i]] <= dq.in_pc[PC_W*i +: PC_W];
            end
        end
    end
endmodule

// File: tb/tb_decode_queue_ooo.sv
// tb_decode_queue_ooo: scoreboard bench for decode_queue_ooo (FETCH_W=2, DEPTH=8, PC_W=64)
module tb_decode_queue_ooo;
    localparam logic [31:0] I_ADD  = 32'h8B030041; // ADD  X1,X2,X3
    localparam logic [31:0] I_LDUR = 32'hF84080A4; // LDUR X4,[X5,#8]
    localparam logic [31:0] I_BL   = 32'h94000010; // BL   +16
    localparam logic [31:0] I_SUBS = 32'hEB0B0149; // SUBS X9,X10,X11
    localparam logic [31:0] I_SUB  = 32'hCB040062; // SUB  X2,X3,X4
    localparam logic [31:0] I_ORR  = 32'hAA0700C5; // ORR  X5,X6,X7
    localparam logic [31:0] I_STUR = 32'hF8000041; // STUR X1,[X2,#0]
    localparam logic [31:0] I_MUL  = 32'h9B050083; // MUL  X3,X4,X5
    localparam logic [31:0] I_ADDI = 32'h91000507; // ADDI X7,X8,#1
    localparam logic [31:0] I_CBZ  = 32'hB4000003; // CBZ  X3
    localparam logic [31:0] I_BAD  = 32'hFFFFFFFF;
`ifdef DQ_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif

    typedef struct packed {
        logic [63:0] pc;
        logic [2:0]  cmd;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        m2r;
        logic        sc;
        logic        ill;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;
    exp_t sb [$];

    always #5 clk = ~clk;

    decode_queue_ooo_if #(.FETCH_W(2), .DEPTH(8), .PC_W(64)) d ();

    decode_queue_ooo #(.FETCH_W(2), .DEPTH(8), .PC_W(64)) dut (
        .clk  (clk),
        .reset(reset),
        .dq   (d.slave)
    );

    function automatic exp_t expect_of(input logic [31:0] ins, input logic [63:0] pc);
        exp_t e;
        case (ins)
            I_ADD:   e = {pc, 3'd0, 5'd1, 5'b10000};
            I_LDUR:  e = {pc, 3'd2, 5'd4, 5'b11100};
            I_BL:    e = {pc, 3'd7, 5'd30, 5'b10000};
            I_SUBS:  e = {pc, 3'd0, 5'd9, 5'b10010};
            I_SUB:   e = {pc, 3'd0, 5'd2, 5'b10000};
            I_ORR:   e = {pc, 3'd0, 5'd5, 5'b10000};
            I_STUR:  e = {pc, 3'd1, 5'd1, 5'b00000};
            I_MUL:   e = {pc, 3'd4, 5'd3, 5'b10000};
            I_ADDI:  e = {pc, 3'd0, 5'd7, 5'b10000};
            I_CBZ:   e = {pc, 3'd5, 5'd3, 5'b00000};
            default: e = {pc, 3'd0, 5'd31, 5'b00001};
        endcase
        return e;
    endfunction

    // Every accepted micro-op is compared in order when the consumer takes it.
    always @(negedge clk) begin
        exp_t got, want;
        #2;
        if (!reset && !d.flush && d.out_valid && d.out_ready) begin
            checks++;
            got = {d.out_pc, d.out_uop.cmd, d.out_uop.rd, d.out_uop.reg_write, d.out_uop.mem_read,
                   d.out_uop.mem_to_reg, d.out_uop.save_cond, d.out_uop.illegal};
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got %h, required no output", got);
            end else begin
                want = sb.pop_front();
                if (got !== want) begin
                    errors++;
                    $display("FAIL pop_order: got %h, required %h", got, want);
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [1:0] lv, input logic [31:0] i0, input logic [31:0] i1,
                         input logic [63:0] p0, input logic [63:0] p1, input logic fl, input logic ordy);
        @(negedge clk);
        d.in_valid = v;
        d.in_lane_valid = lv;
        d.in_instr = {i1, i0};
        d.in_pc = {p1, p0};
        d.flush = fl;
        d.out_ready = ordy;
        if (fl) begin
            sb.delete();
        end else if (v && d.in_ready) begin
            if (lv[0]) sb.push_back(expect_of(i0, p0));
            if (lv[1]) sb.push_back(expect_of(i1, p1));
        end
    endtask

    task automatic idle(input logic ordy);
        drive(1'b0, 2'b00, 32'h0, 32'h0, 64'h0, 64'h0, 1'b0, ordy);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) idle(1'b0);
        @(negedge clk);
        reset = 1'b0;
        checks += 5;
        if (d.occupancy !== 4'd0) begin errors++; $display("FAIL reset_occ: got %0d, required 0", d.occupancy); end
        if (d.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", d.out_valid); end
        if (d.out_uop !== '0) begin errors++; $display("FAIL reset_uop: got %h, required 0", d.out_uop); end
        if (d.out_pc !== 64'h0) begin errors++; $display("FAIL reset_pc: got %h, required 0", d.out_pc); end
        if (d.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b, required 1", d.in_ready); end
    endtask

    task automatic test_basic;
        drive(1'b1, 2'b11, I_ADD, I_LDUR, 64'h100, 64'h104, 1'b0, 1'b0);
        idle(1'b1);
        checks += 3;
        if (d.occupancy !== 4'd2) begin errors++; $display("FAIL basic_occ: got %0d, required 2", d.occupancy); end
        if (d.out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b, required 1", d.out_valid); end
        if ({d.out_uop.cmd, d.out_uop.rd, d.out_uop.reg_write} !== {3'd0, 5'd1, 1'b1}) begin
            errors++;
            $display("FAIL basic_add: got cmd=%0d rd=%0d rw=%b, required cmd=0 rd=1 rw=1",
                     d.out_uop.cmd, d.out_uop.rd, d.out_uop.reg_write);
        end
        idle(1'b1);
        checks++;
        if ({d.out_uop.cmd, d.out_uop.mem_read, d.out_uop.mem_to_reg} !== {3'd2, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL basic_ldur: got cmd=%0d mr=%b m2r=%b, required cmd=2 mr=1 m2r=1",
                     d.out_uop.cmd, d.out_uop.mem_read, d.out_uop.mem_to_reg);
        end
        idle(1'b0);
        checks++;
        if (d.occupancy !== 4'd0) begin errors++; $display("FAIL basic_drain: got %0d, required 0", d.occupancy); end
    endtask

    task automatic test_full;
        drive(1'b1, 2'b11, I_SUB, I_ORR, 64'h200, 64'h204, 1'b0, 1'b0);
        drive(1'b1, 2'b11, I_STUR, I_MUL, 64'h208, 64'h20C, 1'b0, 1'b0);
        drive(1'b1, 2'b11, I_ADDI, I_CBZ, 64'h210, 64'h214, 1'b0, 1'b0);
        checks++;
        if (d.in_ready !== 1'b1) begin errors++; $display("FAIL full_ready6: got %b, required 1", d.in_ready); end
        drive(1'b1, 2'b11, I_ADD, I_LDUR, 64'h218, 64'h21C, 1'b0, 1'b0);
        drive(1'b1, 2'b11, I_SUBS, I_BL, 64'h900, 64'h904, 1'b0, 1'b0);
        checks += 2;
        if (d.occupancy !== 4'd8) begin errors++; $display("FAIL full_occ: got %0d, required 8", d.occupancy); end
        if (d.in_ready !== 1'b0) begin errors++; $display("FAIL full_ready8: got %b, required 0", d.in_ready); end
        idle(1'b0);
        checks++;
        if (d.occupancy !== 4'd8) begin errors++; $display("FAIL full_reject: got %0d, required 8", d.occupancy); end
        repeat (8) idle(1'b1);
        idle(1'b0);
        checks++;
        if (d.occupancy !== 4'd0) begin errors++; $display("FAIL full_drain: got %0d, required 0", d.occupancy); end
    endtask

    task automatic test_hole;
        drive(1'b1, 2'b10, I_ADD, I_BL, 64'h300, 64'h304, 1'b0, 1'b0);
        idle(1'b0);
        checks += 2;
        if (d.occupancy !== 4'd1) begin errors++; $display("FAIL hole_occ: got %0d, required 1", d.occupancy); end
        if ({d.out_uop.cmd, d.out_uop.rd, d.out_pc} !== {3'd7, 5'd30, 64'h304}) begin
            errors++;
            $display("FAIL hole_bl: got cmd=%0d rd=%0d pc=%h, required cmd=7 rd=30 pc=304",
                     d.out_uop.cmd, d.out_uop.rd, d.out_pc);
        end
        idle(1'b1);
        idle(1'b0);
    endtask

    task automatic test_illegal;
        drive(1'b1, 2'b01, I_BAD, I_ADD, 64'h400, 64'h404, 1'b0, 1'b0);
        idle(1'b0);
        checks++;
        if ({d.out_uop.illegal, d.out_uop.reg_write, d.out_uop.mem_write, d.out_uop.cmd} !== {3'b100, 3'd0}) begin
            errors++;
            $display("FAIL illegal: got ill=%b rw=%b mw=%b cmd=%0d, required ill=1 rw=0 mw=0 cmd=0",
                     d.out_uop.illegal, d.out_uop.reg_write, d.out_uop.mem_write, d.out_uop.cmd);
        end
        idle(1'b1);
        idle(1'b0);
    endtask

    task automatic test_flush;
        drive(1'b1, 2'b11, I_SUB, I_ORR, 64'h500, 64'h504, 1'b0, 1'b0);
        drive(1'b1, 2'b11, I_STUR, I_MUL, 64'h508, 64'h50C, 1'b0, 1'b0);
        drive(1'b1, 2'b01, I_ADDI, I_CBZ, 64'h510, 64'h514, 1'b0, 1'b0);
        idle(1'b0);
        checks++;
        if (d.occupancy !== 4'd5) begin errors++; $display("FAIL flush_pre: got %0d, required 5", d.occupancy); end
        drive(1'b1, 2'b11, I_ADD, I_LDUR, 64'h600, 64'h604, 1'b1, 1'b1);
        idle(1'b0);
        checks += 2;
        if (d.occupancy !== 4'd0) begin errors++; $display("FAIL flush_occ: got %0d, required 0", d.occupancy); end
        if (d.out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b, required 0", d.out_valid); end
        idle(1'b0);
        checks++;
        if (d.out_pc !== 64'h0) begin errors++; $display("FAIL flush_pc: got %h, required 0", d.out_pc); end
    endtask

    task automatic test_back_to_back;
        drive(1'b1, 2'b11, I_CBZ, I_ADDI, 64'h800, 64'h804, 1'b0, 1'b1);
        drive(1'b1, 2'b11, I_SUB, I_ORR, 64'h808, 64'h80C, 1'b0, 1'b1);
        drive(1'b1, 2'b11, I_STUR, I_MUL, 64'h810, 64'h814, 1'b0, 1'b1);
        idle(1'b1);
        checks++;
        if (d.occupancy !== 4'(4 - BYP)) begin
            errors++;
            $display("FAIL b2b_occ: got %0d, required %0d", d.occupancy, 4 - BYP);
        end
        repeat (4) idle(1'b1);
        idle(1'b0);
        checks++;
        if (d.occupancy !== 4'd0) begin errors++; $display("FAIL b2b_drain: got %0d, required 0", d.occupancy); end
    endtask

`ifdef DQ_BYPASS_EN
    task automatic test_bypass;
        drive(1'b1, 2'b01, I_SUBS, I_ADD, 64'h700, 64'h704, 1'b0, 1'b1);
        #1;
        checks += 2;
        if (d.out_valid !== 1'b1) begin errors++; $display("FAIL bypass_valid: got %b, required 1", d.out_valid); end
        if ({d.out_uop.save_cond, d.out_pc} !== {1'b1, 64'h700}) begin
            errors++;
            $display("FAIL bypass_uop: got sc=%b pc=%h, required sc=1 pc=700", d.out_uop.save_cond, d.out_pc);
        end
        idle(1'b0);
        checks++;
        if (d.occupancy !== 4'd0) begin errors++; $display("FAIL bypass_occ: got %0d, required 0", d.occupancy); end
    endtask
`else
    task automatic test_latency;
        drive(1'b1, 2'b01, I_SUBS, I_ADD, 64'h700, 64'h704, 1'b0, 1'b1);
        #1;
        checks++;
        if (d.out_valid !== 1'b0) begin errors++; $display("FAIL latency_same: got %b, required 0", d.out_valid); end
        idle(1'b1);
        checks++;
        if ({d.out_valid, d.out_uop.save_cond} !== 2'b11) begin
            errors++;
            $display("FAIL latency_next: got valid=%b sc=%b, required valid=1 sc=1", d.out_valid, d.out_uop.save_cond);
        end
        idle(1'b0);
        checks++;
        if (d.occupancy !== 4'd0) begin errors++; $display("FAIL latency_occ: got %0d, required 0", d.occupancy); end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        d.flush = 1'b0;
        d.in_valid = 1'b0;
        d.in_lane_valid = '0;
        d.in_instr = '0;
        d.in_pc = '0;
        d.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_full();
        test_hole();
        test_illegal();
        test_flush();
        test_back_to_back();
`ifdef DQ_BYPASS_EN
        test_bypass();
`else
        test_latency();
`endif
        idle(1'b0);
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_empty: got %0d left, required 0", sb.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
